// File: rtl/tl_indicator_pkg.sv
// Shared constants and types for the TileLink-UL test-indicator arbiter.
package tl_indicator_pkg;

  // TileLink-UL A-channel opcodes
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;

  // TileLink-UL D-channel opcodes
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  // Field widths of the indicator port
  localparam int OP_W    = 3;
  localparam int PARAM_W = 3;
  localparam int SIZE_W  = 2;
  localparam int SRC_W   = 12;
  localparam int ADDR_W  = 15;
  localparam int MASK_W  = 4;
  localparam int DATA_W  = 32;

  // A-channel arbitration state: free to pick, or locked on a stalled beat
  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tl_indicator_order_fifo.sv
// Grant-order FIFO: remembers which requester issued each outstanding A beat
// so the in-order D responses can be routed back.
module tl_indicator_order_fifo
  import tl_indicator_pkg::*;
#(
  parameter int IDX_W = 2,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [IDX_W-1:0] head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] mem [DEPTH];

  // Wrap bit distinguishes full from empty when the address bits match
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Read/write pointers; the only state cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tl_indicator_arbiter.sv
// Round-robin A-channel arbiter for the shared test-indicator slave port, with
// grant locking on stalled beats and in-order D routing via a grant-order FIFO.
module tl_indicator_arbiter
  import tl_indicator_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  // requester-side A channel
  input  logic [NREQ-1:0]          in_a_valid,
  output logic [NREQ-1:0]          in_a_ready,
  input  logic [NREQ*OP_W-1:0]     in_a_opcode,
  input  logic [NREQ*PARAM_W-1:0]  in_a_param,
  input  logic [NREQ*SIZE_W-1:0]   in_a_size,
  input  logic [NREQ*SRC_W-1:0]    in_a_source,
  input  logic [NREQ*ADDR_W-1:0]   in_a_address,
  input  logic [NREQ*MASK_W-1:0]   in_a_mask,
  input  logic [NREQ*DATA_W-1:0]   in_a_data,
  input  logic [NREQ-1:0]          in_a_corrupt,
  // slave-side A channel
  output logic                     out_a_valid,
  input  logic                     out_a_ready,
  output logic [OP_W-1:0]          out_a_opcode,
  output logic [PARAM_W-1:0]       out_a_param,
  output logic [SIZE_W-1:0]        out_a_size,
  output logic [SRC_W-1:0]         out_a_source,
  output logic [ADDR_W-1:0]        out_a_address,
  output logic [MASK_W-1:0]        out_a_mask,
  output logic [DATA_W-1:0]        out_a_data,
  output logic                     out_a_corrupt,
  // slave-side D channel
  input  logic                     out_d_valid,
  output logic                     out_d_ready,
  input  logic [OP_W-1:0]          out_d_opcode,
  input  logic [SIZE_W-1:0]        out_d_size,
  input  logic [SRC_W-1:0]         out_d_source,
  input  logic [DATA_W-1:0]        out_d_data,
  input  logic                     out_d_denied,
  // requester-side D channel
  output logic [NREQ-1:0]          in_d_valid,
  input  logic [NREQ-1:0]          in_d_ready,
  output logic [OP_W-1:0]          in_d_opcode,
  output logic [SIZE_W-1:0]        in_d_size,
  output logic [SRC_W-1:0]         in_d_source,
  output logic [DATA_W-1:0]        in_d_data,
  output logic                     in_d_denied,
  // status
  output logic                     orphan_d
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  // Next requester index, wrapping at NREQ (NREQ need not be a power of 2)
  function automatic idx_t wrap_inc(input idx_t idx);
    if (idx == idx_t'(NREQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // First valid requester at or after ptr, scanning upward modulo NREQ
  function automatic idx_t rr_pick(input logic [NREQ-1:0] valid, input idx_t ptr);
    idx_t pick  = ptr;
    idx_t cand  = ptr;
    logic found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = wrap_inc(cand);
    end
    return pick;
  endfunction

  arb_state_e state;
  arb_state_e state_nx;
  idx_t       rr_ptr;
  idx_t       rr_ptr_nx;
  idx_t       lock_idx;
  idx_t       lock_idx_nx;
  idx_t       grant;
  idx_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       a_fire;
  logic       d_pop;

  // Grant selection: locked requester in HOLD keeps the A beat stable
  always_comb begin
    grant = rr_pick(in_a_valid, rr_ptr);
    if (state == HOLD) grant = lock_idx;
  end

  // A handshake: no beat is offered while the order FIFO is full, and a
  // same-cycle D pop does not bypass into a ready
  assign out_a_valid = !reset && in_a_valid[grant] && !fifo_full;
  assign a_fire      = out_a_valid && out_a_ready;

  // Ready goes back only to the granted requester, and only on a real fire
  always_comb begin
    in_a_ready = '0;
    if (a_fire) in_a_ready[grant] = 1'b1;
  end

  // A field mux from the granted lane
  assign out_a_opcode  = in_a_opcode [int'(grant)*OP_W    +: OP_W];
  assign out_a_param   = in_a_param  [int'(grant)*PARAM_W +: PARAM_W];
  assign out_a_size    = in_a_size   [int'(grant)*SIZE_W  +: SIZE_W];
  assign out_a_source  = in_a_source [int'(grant)*SRC_W   +: SRC_W];
  assign out_a_address = in_a_address[int'(grant)*ADDR_W  +: ADDR_W];
  assign out_a_mask    = in_a_mask   [int'(grant)*MASK_W  +: MASK_W];
  assign out_a_data    = in_a_data   [int'(grant)*DATA_W  +: DATA_W];
  assign out_a_corrupt = in_a_corrupt[grant];

  // Arbiter next-state: stalled beat locks the grant, a fire advances rr_ptr
  always_comb begin
    state_nx    = state;
    rr_ptr_nx   = rr_ptr;
    lock_idx_nx = lock_idx;
    case (state)
      ARB: begin
        if (a_fire) begin
          rr_ptr_nx = wrap_inc(grant);
        end else if (out_a_valid) begin
          lock_idx_nx = grant;
          state_nx    = HOLD;
        end
      end
      HOLD: begin
        if (a_fire) begin
          rr_ptr_nx = wrap_inc(lock_idx);
          state_nx  = ARB;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  // Arbiter state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ARB;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      lock_idx <= lock_idx_nx;
    end
  end

  tl_indicator_order_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clock (clock),
    .reset (reset),
    .push  (a_fire),
    .din   (grant),
    .pop   (d_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // D routing: head of the order FIFO owns the response; with nothing
  // outstanding the beat is accepted and dropped
  always_comb begin
    in_d_valid  = '0;
    out_d_ready = 1'b0;
    if (!reset) begin
      if (fifo_empty) begin
        out_d_ready = out_d_valid;
      end else begin
        in_d_valid[head] = out_d_valid;
        out_d_ready      = in_d_ready[head];
      end
    end
  end

  assign d_pop = out_d_valid && out_d_ready && !fifo_empty;

  // D fields are broadcast; only in_d_valid selects the recipient
  assign in_d_opcode = out_d_opcode;
  assign in_d_size   = out_d_size;
  assign in_d_source = out_d_source;
  assign in_d_data   = out_d_data;
  assign in_d_denied = out_d_denied;

  // Sticky flag for D beats that arrive with no outstanding A beat
  always_ff @(posedge clock) begin
    if (reset) begin
      orphan_d <= 1'b0;
    end else if (out_d_valid && fifo_empty) begin
      orphan_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_indicator_arbiter.sv
// Testbench for tl_indicator_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_tl_indicator_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   in_a_valid;
  logic [NREQ-1:0]   in_a_ready;
  logic [NREQ*3-1:0] in_a_opcode;
  logic [NREQ*3-1:0] in_a_param;
  logic [NREQ*2-1:0] in_a_size;
  logic [NREQ*12-1:0] in_a_source;
  logic [NREQ*15-1:0] in_a_address;
  logic [NREQ*4-1:0] in_a_mask;
  logic [NREQ*32-1:0] in_a_data;
  logic [NREQ-1:0]   in_a_corrupt;
  logic              out_a_valid;
  logic              out_a_ready;
  logic [2:0]        out_a_opcode;
  logic [2:0]        out_a_param;
  logic [1:0]        out_a_size;
  logic [11:0]       out_a_source;
  logic [14:0]       out_a_address;
  logic [3:0]        out_a_mask;
  logic [31:0]       out_a_data;
  logic              out_a_corrupt;
  logic              out_d_valid;
  logic              out_d_ready;
  logic [2:0]        out_d_opcode;
  logic [1:0]        out_d_size;
  logic [11:0]       out_d_source;
  logic [31:0]       out_d_data;
  logic              out_d_denied;
  logic [NREQ-1:0]   in_d_valid;
  logic [NREQ-1:0]   in_d_ready;
  logic [2:0]        in_d_opcode;
  logic [1:0]        in_d_size;
  logic [11:0]       in_d_source;
  logic [31:0]       in_d_data;
  logic              in_d_denied;
  logic              orphan_d;

  int checks = 0;
  int errors = 0;

  tl_indicator_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .in_a_corrupt(in_a_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
    .out_d_denied(out_d_denied),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_data(in_d_data),
    .in_d_denied(in_d_denied),
    .orphan_d(orphan_d)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [31:0] d,
                          input logic [14:0] addr);
    in_a_valid[i]           = v;
    in_a_opcode[i*3 +: 3]   = 3'd0;
    in_a_param[i*3 +: 3]    = 3'd0;
    in_a_size[i*2 +: 2]     = 2'd2;
    in_a_source[i*12 +: 12] = 12'h100 + 12'(i);
    in_a_address[i*15 +: 15] = addr;
    in_a_mask[i*4 +: 4]     = 4'hF;
    in_a_data[i*32 +: 32]   = d;
    in_a_corrupt[i]         = 1'b0;
  endtask

  task automatic clear_inputs();
    in_a_valid = '0; in_a_opcode = '0; in_a_param = '0; in_a_size = '0;
    in_a_source = '0; in_a_address = '0; in_a_mask = '0; in_a_data = '0;
    in_a_corrupt = '0; out_a_ready = 1'b0;
    out_d_valid = 1'b0; out_d_opcode = 3'd0; out_d_size = 2'd2; out_d_source = '0;
    out_d_data = '0; out_d_denied = 1'b0; in_d_ready = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Expected round-robin choice: first valid at or after ptr, modulo NREQ
  function automatic int rr_expect(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return ptr;
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b exp 0", out_a_valid); end
    checks++; if (in_a_ready !== 4'b0) begin errors++; $display("FAIL reset_a_ready got %b exp 0000", in_a_ready); end
    checks++; if (in_d_valid !== 4'b0) begin errors++; $display("FAIL reset_d_valid got %b exp 0000", in_d_valid); end
    checks++; if (out_d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready got %b exp 0", out_d_ready); end
    checks++; if (orphan_d !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b exp 0", orphan_d); end
  endtask

  task automatic test_single_put();
    do_reset();
    set_lane(2, 1'b1, 32'h5555, 15'h000);
    out_a_ready = 1'b1;
    #1;
    checks++; if (out_a_valid !== 1'b1) begin errors++; $display("FAIL put_a_valid got %b exp 1", out_a_valid); end
    checks++; if (in_a_ready !== 4'b0100) begin errors++; $display("FAIL put_a_ready got %b exp 0100", in_a_ready); end
    checks++; if (out_a_data !== 32'h5555) begin errors++; $display("FAIL put_data got %h exp 00005555", out_a_data); end
    checks++; if (out_a_address !== 15'h0 || out_a_mask !== 4'hF) begin errors++; $display("FAIL put_addr_mask got %h/%h exp 0000/f", out_a_address, out_a_mask); end
    checks++; if (out_a_source !== 12'h102) begin errors++; $display("FAIL put_source got %h exp 102", out_a_source); end
    tick();
    set_lane(2, 1'b0, 32'h0, 15'h0);
    out_a_ready = 1'b0;
    out_d_valid = 1'b1; out_d_opcode = 3'd0; in_d_ready = 4'hF;
    #1;
    checks++; if (in_d_valid !== 4'b0100) begin errors++; $display("FAIL put_d_route got %b exp 0100", in_d_valid); end
    checks++; if (out_d_ready !== 1'b1) begin errors++; $display("FAIL put_d_ready got %b exp 1", out_d_ready); end
    tick();
    out_d_valid = 1'b0;
  endtask

  task automatic test_round_robin_full();
    logic [3:0] exp_route [4];
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, 32'hA0 + 32'(i), 15'(i));
    out_a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (in_a_ready !== 4'(1 << k)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, in_a_ready, 4'(1 << k)); end
      checks++; if (out_a_data !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL rr_data%0d got %h exp %h", k, out_a_data, 32'hA0 + 32'(k)); end
      tick();
    end
    #1;
    checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL full_a_valid got %b exp 0", out_a_valid); end
    checks++; if (in_a_ready !== 4'b0) begin errors++; $display("FAIL full_a_ready got %b exp 0000", in_a_ready); end
    tick();
    out_d_valid = 1'b1; in_d_ready = 4'hF;
    #1;
    checks++; if (in_d_valid !== 4'b0001) begin errors++; $display("FAIL full_pop_route got %b exp 0001", in_d_valid); end
    checks++; if (in_a_ready !== 4'b0) begin errors++; $display("FAIL full_no_bypass got %b exp 0000", in_a_ready); end
    tick();
    out_d_valid = 1'b0;
    #1;
    checks++; if (in_a_ready !== 4'b0001) begin errors++; $display("FAIL full_resume got %b exp 0001", in_a_ready); end
    tick();
    in_a_valid = '0; out_a_ready = 1'b0;
    exp_route[0] = 4'b0010; exp_route[1] = 4'b0100; exp_route[2] = 4'b1000; exp_route[3] = 4'b0001;
    out_d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (in_d_valid !== exp_route[k]) begin errors++; $display("FAIL rr_d_route%0d got %b exp %b", k, in_d_valid, exp_route[k]); end
      tick();
    end
    out_d_valid = 1'b0;
  endtask

  task automatic test_hold();
    logic [3:0] exp_route [3];
    do_reset();
    set_lane(0, 1'b1, 32'h10, 15'h10);
    out_a_ready = 1'b1;
    #1;
    checks++; if (in_a_ready !== 4'b0001) begin errors++; $display("FAIL hold_first got %b exp 0001", in_a_ready); end
    tick();
    set_lane(0, 1'b1, 32'h11, 15'h11);
    set_lane(1, 1'b1, 32'h21, 15'h21);
    out_a_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_lane(3, 1'b1, 32'h31, 15'h31);
      #1;
      checks++; if (out_a_valid !== 1'b1 || out_a_data !== 32'h21) begin errors++; $display("FAIL hold_stall%0d got v=%b d=%h exp v=1 d=00000021", k, out_a_valid, out_a_data); end
      checks++; if (in_a_ready !== 4'b0) begin errors++; $display("FAIL hold_ready%0d got %b exp 0000", k, in_a_ready); end
      tick();
    end
    out_a_ready = 1'b1;
    #1;
    checks++; if (in_a_ready !== 4'b0010 || out_a_data !== 32'h21) begin errors++; $display("FAIL hold_fire got r=%b d=%h exp r=0010 d=00000021", in_a_ready, out_a_data); end
    tick();
    set_lane(1, 1'b0, 32'h0, 15'h0);
    #1;
    checks++; if (in_a_ready !== 4'b1000 || out_a_data !== 32'h31) begin errors++; $display("FAIL hold_next got r=%b d=%h exp r=1000 d=00000031", in_a_ready, out_a_data); end
    tick();
    in_a_valid = '0; out_a_ready = 1'b0;
    exp_route[0] = 4'b0001; exp_route[1] = 4'b0010; exp_route[2] = 4'b1000;
    out_d_valid = 1'b1; in_d_ready = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_d_valid !== exp_route[k]) begin errors++; $display("FAIL hold_d_route%0d got %b exp %b", k, in_d_valid, exp_route[k]); end
      tick();
    end
    out_d_valid = 1'b0;
  endtask

  task automatic test_d_stall();
    do_reset();
    set_lane(2, 1'b1, 32'h77, 15'h7);
    out_a_ready = 1'b1;
    tick();
    in_a_valid = '0; out_a_ready = 1'b0;
    out_d_valid = 1'b1; in_d_ready = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (out_d_ready !== 1'b0) begin errors++; $display("FAIL dstall_ready%0d got %b exp 0", k, out_d_ready); end
      checks++; if (in_d_valid !== 4'b0100) begin errors++; $display("FAIL dstall_route%0d got %b exp 0100", k, in_d_valid); end
      tick();
    end
    in_d_ready = 4'b0100;
    #1;
    checks++; if (out_d_ready !== 1'b1) begin errors++; $display("FAIL dstall_release got %b exp 1", out_d_ready); end
    tick();
    out_d_valid = 1'b0;
    #1;
    checks++; if (orphan_d !== 1'b0 || out_d_ready !== 1'b0) begin errors++; $display("FAIL dstall_after got orphan=%b ready=%b exp 0/0", orphan_d, out_d_ready); end
  endtask

  task automatic test_orphan();
    do_reset();
    out_d_valid = 1'b1;
    #1;
    checks++; if (out_d_ready !== 1'b1 || in_d_valid !== 4'b0) begin errors++; $display("FAIL orphan_accept got ready=%b route=%b exp 1/0000", out_d_ready, in_d_valid); end
    tick();
    out_d_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (orphan_d !== 1'b1) begin errors++; $display("FAIL orphan_sticky%0d got %b exp 1", k, orphan_d); end
      tick();
    end
    do_reset();
    #1;
    checks++; if (orphan_d !== 1'b0) begin errors++; $display("FAIL orphan_cleared got %b exp 0", orphan_d); end
    out_d_valid = 1'b1;
    #1;
    checks++; if (in_d_valid !== 4'b0 || out_d_ready !== 1'b1) begin errors++; $display("FAIL orphan_fifo_empty got route=%b ready=%b exp 0000/1", in_d_valid, out_d_ready); end
    out_d_valid = 1'b0;
  endtask

  task automatic test_random();
    int q[$];
    int rr = 0;
    bit locked = 1'b0;
    int lock_idx = 0;
    bit orph = 1'b0;
    int g;
    bit empty;
    bit exp_av;
    bit exp_dr;
    logic [3:0] exp_ir;
    logic [3:0] exp_dv;
    logic [31:0] lane_d [NREQ];
    logic [14:0] lane_a [NREQ];
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (locked && i == lock_idx) begin
          set_lane(i, 1'b1, lane_d[i], lane_a[i]);
        end else begin
          lane_d[i] = $urandom;
          lane_a[i] = 15'($urandom);
          set_lane(i, ($urandom % 3) == 0, lane_d[i], lane_a[i]);
        end
      end
      out_a_ready  = ($urandom % 4) != 0;
      out_d_valid  = (q.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 32) == 0);
      out_d_data   = $urandom;
      out_d_opcode = 3'($urandom % 2);
      in_d_ready   = 4'($urandom);
      #1;
      g      = locked ? lock_idx : rr_expect(in_a_valid, rr);
      exp_av = (locked || (in_a_valid != 0)) && (q.size() < DEPTH);
      exp_ir = (exp_av && out_a_ready) ? 4'(1 << g) : 4'b0;
      empty  = (q.size() == 0);
      exp_dv = (!empty && out_d_valid) ? 4'(1 << q[0]) : 4'b0;
      exp_dr = empty ? out_d_valid : in_d_ready[q[0]];
      checks++; if (out_a_valid !== exp_av) begin errors++; $display("FAIL rnd_a_valid c%0d got %b exp %b", c, out_a_valid, exp_av); end
      checks++; if (in_a_ready !== exp_ir) begin errors++; $display("FAIL rnd_a_ready c%0d got %b exp %b", c, in_a_ready, exp_ir); end
      if (exp_av) begin
        checks++; if (out_a_data !== lane_d[g] || out_a_address !== lane_a[g] || out_a_source !== 12'h100 + 12'(g)) begin errors++; $display("FAIL rnd_a_fields c%0d got %h/%h/%h exp %h/%h/%h", c, out_a_data, out_a_address, out_a_source, lane_d[g], lane_a[g], 12'h100 + 12'(g)); end
      end
      checks++; if (in_d_valid !== exp_dv) begin errors++; $display("FAIL rnd_d_valid c%0d got %b exp %b", c, in_d_valid, exp_dv); end
      checks++; if (out_d_ready !== exp_dr) begin errors++; $display("FAIL rnd_d_ready c%0d got %b exp %b", c, out_d_ready, exp_dr); end
      checks++; if (in_d_data !== out_d_data || in_d_opcode !== out_d_opcode) begin errors++; $display("FAIL rnd_d_fields c%0d got %h/%h exp %h/%h", c, in_d_data, in_d_opcode, out_d_data, out_d_opcode); end
      checks++; if (orphan_d !== orph) begin errors++; $display("FAIL rnd_orphan c%0d got %b exp %b", c, orphan_d, orph); end
      // advance the model to the state after this clock edge
      if (empty && out_d_valid) orph = 1'b1;
      if (!empty && out_d_valid && exp_dr) void'(q.pop_front());
      if (exp_av && out_a_ready) begin
        q.push_back(g);
        rr = (g + 1) % NREQ;
        locked = 1'b0;
      end else if (exp_av) begin
        locked = 1'b1;
        lock_idx = g;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_single_put();
    test_round_robin_full();
    test_hold();
    test_d_stall();
    test_orphan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
